mod_cnt_sequencer: RTL and testbench



---
 rtl/counter_pkg.sv | 14 +
 rtl/mod_m_counter.sv | 34 +++
 rtl/mod_cnt_sequencer.sv | 111 +++++++++++
 tb/tb_mod_cnt_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter blocks: sequencer state encoding and default sizes.
package counter_pkg;

  localparam int DEF_MOD = 5;
  localparam int DEF_CW  = 3;
  localparam int DEF_NW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mod_m_counter.sv
// Modulo-MOD up counter with synchronous clear and a terminal-count strobe.
module mod_m_counter
  import counter_pkg::*;
#(
  parameter int MOD = DEF_MOD,
  parameter int CW  = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] qout,
  output logic          tc
);

  logic [CW-1:0] r_q;
  logic          w_last;

  assign w_last = (r_q == CW'(MOD - 1));
  assign tc     = en & w_last;
  assign qout   = r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_last ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/mod_cnt_sequencer.sv
// Run controller around mod_m_counter: counts N full periods per start, then pulses done.
// Optional macro AUTO_RESTART_EN: restart automatically on the final wrap instead of finishing.
module mod_cnt_sequencer
  import counter_pkg::*;
#(
  parameter int MOD = DEF_MOD,
  parameter int CW  = DEF_CW,
  parameter int NW  = DEF_NW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic [NW-1:0] num_wraps,
  output logic [CW-1:0] qout,
  output logic          z,
  output logic [NW-1:0] wrap_cnt,
  output logic          busy,
  output logic          done
);

  seq_state_t    r_state, w_state_nxt;
  logic [NW-1:0] r_target, w_target_nxt;
  logic [NW-1:0] r_wrap_cnt, w_wrap_nxt;
  logic          r_done, w_done_nxt;

  logic          w_en;
  logic          w_clr;
  logic          w_tc;
  logic [NW-1:0] w_wrap_inc;

  assign w_en       = (r_state == ST_RUN) && !pause;
  // Abort and an accepted start both force the counter back to zero.
  assign w_clr      = abort || ((r_state == ST_IDLE) && start);
  assign w_wrap_inc = r_wrap_cnt + NW'(1);

  mod_m_counter #(
    .MOD (MOD),
    .CW  (CW)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_en),
    .clr   (w_clr),
    .qout  (qout),
    .tc    (w_tc)
  );

  assign z        = w_tc;
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign wrap_cnt = r_wrap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_wrap_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_wrap_cnt <= w_wrap_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_wrap_nxt   = r_wrap_cnt;
    w_done_nxt   = 1'b0;

    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_target_nxt = num_wraps;
            w_wrap_nxt   = '0;
            if (num_wraps == '0) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_tc) begin
            w_wrap_nxt = w_wrap_inc;
            if (w_wrap_inc == r_target) begin
              w_done_nxt = 1'b1;
`ifdef AUTO_RESTART_EN
              w_wrap_nxt = '0;
`else
              w_state_nxt = ST_DONE;
`endif
            end
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_cnt_sequencer.sv
// Self-checking bench for mod_cnt_sequencer: vector table, directed corner sequences, random run vs model.
module tb_mod_cnt_sequencer;

  localparam int MOD = 5;
  localparam int CW  = 3;
  localparam int NW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, pause, abort;
  logic [NW-1:0] num_wraps;
  logic [CW-1:0] qout;
  logic          z;
  logic [NW-1:0] wrap_cnt;
  logic          busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a run is a count of enabled ticks; position and wraps follow by division.
  int m_phase;   // 0 idle, 1 running, 2 finishing
  int m_ticks;
  int m_target;
  int m_wraps;
  bit m_done;

  bit last_z, last_done, last_busy;

  mod_cnt_sequencer #(.MOD(MOD), .CW(CW), .NW(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .num_wraps (num_wraps),
    .qout      (qout),
    .z         (z),
    .wrap_cnt  (wrap_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_q();
    return (m_phase == 1) ? (m_ticks % MOD) : 0;
  endfunction

  function automatic bit exp_z(input bit p);
    return (m_phase == 1) && !p && ((m_ticks % MOD) == MOD - 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_target = 0; m_wraps = 0; m_done = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit a, input int nw);
    if (a) begin
      m_phase = 0;
      m_done  = 0;
    end else if (m_phase == 0) begin
      m_done = 0;
      if (s) begin
        m_target = nw; m_ticks = 0; m_wraps = 0;
        if (nw == 0) begin m_phase = 2; m_done = 1; end
        else m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_done = 0;
      if (!p) begin
        m_ticks++;
        m_wraps = m_ticks / MOD;
        if (m_ticks == MOD * m_target) begin
          m_done = 1;
`ifdef AUTO_RESTART_EN
          m_ticks = 0;
          m_wraps = 0;
`else
          m_phase = 2;
`endif
        end
      end
    end else begin
      m_phase = 0;
      m_done  = 0;
    end
  endtask

  // One clock: drive at negedge, sample z before the edge, sample registers 1 time unit after it.
  task automatic step(input bit s, input bit p, input bit a, input int nw, input bit chk);
    @(negedge clk);
    start = s; pause = p; abort = a; num_wraps = NW'(nw);
    #1;
    last_z = z;
    if (chk) check("z", z, exp_z(p));
    @(posedge clk);
    model_step(s, p, a, nw);
    #1;
    last_done = done;
    last_busy = busy;
    if (chk) begin
      check("qout", qout, exp_q());
      check("wrap_cnt", wrap_cnt, m_wraps);
      check("busy", busy, m_phase == 1);
      check("done", done, m_done);
    end
  endtask

  typedef struct packed {
    logic          s, p, a;
    logic [NW-1:0] nw;
    logic [CW-1:0] q;
    logic          busy, done;
    logic [NW-1:0] wrap;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int done_at, busy_cycles, zmask, n_done;
    bit busy_dropped;

    rst_n = 1'b0; start = 0; pause = 0; abort = 0; num_wraps = '0;
    model_reset();
    #12;
    check("reset_qout", qout, 0);
    check("reset_wrap", wrap_cnt, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_z", z, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef AUTO_RESTART_EN
    // Zero start, start+abort, abort mid-run, ignored start during a run.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b1, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'd2, 3'd0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'd2, 3'd0, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd2, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd4, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd1, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd2, 1'b1, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 1'b1, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd0, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 8'd1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'd1, 3'd0, 1'b1, 1'b0, 8'd0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 8'd7, 3'd1, 1'b1, 1'b0, 8'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd2, 1'b1, 1'b0, 8'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 1'b1, 1'b0, 8'd0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd4, 1'b1, 1'b0, 8'd0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b1, 8'd1};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 8'd1};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].a, int'(tbl[i].nw), 1'b0);
      check($sformatf("vec%0d_qout", i), qout, tbl[i].q);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("vec%0d_done", i), done, tbl[i].done);
      check($sformatf("vec%0d_wrap", i), wrap_cnt, tbl[i].wrap);
    end

    // Basic run of three periods: z at cycles 5/10/15, 15 busy cycles, done after edge 15.
    step(1, 0, 0, 3, 1'b1);
    busy_cycles = last_busy ? 1 : 0;
    zmask = 0; done_at = -1;
    for (int i = 1; i <= 30; i++) begin
      step(0, 0, 0, 0, 1'b1);
      if (last_z) zmask |= (1 << i);
      if (last_busy) busy_cycles++;
      if (last_done && done_at < 0) done_at = i;
    end
    check("basic_zmask", zmask, (1 << 5) | (1 << 10) | (1 << 15));
    check("basic_busy_cycles", busy_cycles, 15);
    check("basic_done_edge", done_at, 15);
    check("basic_wrap_final", wrap_cnt, 3);

    // Pause for three cycles at qout=2 stretches a one-period run from 5 to 8 cycles.
    step(1, 0, 0, 1, 1'b1);
    done_at = -1; zmask = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, (i >= 3 && i <= 5), 0, 0, 1'b1);
      if (i >= 3 && i <= 5) begin
        check("pause_qout_hold", qout, 2);
        if (last_z) zmask++;
      end
      if (last_done && done_at < 0) done_at = i;
    end
    check("pause_z_quiet", zmask, 0);
    check("pause_done_edge", done_at, 8);
`else
    // Auto-restart: done every 10 cycles, busy never drops, wrap_cnt alternates 0/1.
    step(1, 0, 0, 2, 1'b1);
    n_done = 0; done_at = -1; busy_dropped = 0;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0, 1'b1);
      if (!last_busy) busy_dropped = 1;
      if (last_done) begin
        n_done++;
        if (done_at < 0) done_at = i;
      end
    end
    check("auto_done_count", n_done, 4);
    check("auto_first_done", done_at, 10);
    check("auto_busy_held", busy_dropped, 0);
    step(0, 0, 1, 0, 1'b1);
`endif

    // Asynchronous reset mid-run at qout=2 after one completed period.
    step(1, 0, 0, 3, 1'b1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1'b1);
    check("prereset_qout", qout, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_qout", qout, 0);
    check("async_wrap", wrap_cnt, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_z", z, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 40) == 0), int'($urandom_range(0, 4)), 1'b1);
    end
    step(0, 0, 1, 0, 1'b1);
    step(0, 0, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
